// File: rtl/voice_mixer_pdm.sv
// rtl/voice_mixer_pdm.sv - voice mixer with master volume, saturation and first-order delta-sigma PDM output
module voice_mixer_pdm #(
  parameter int BITDEPTH   = 14,
  parameter int NUM_VOICES = 4,
  parameter int VOLBITS    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_clock,
  input  logic [NUM_VOICES*BITDEPTH-1:0] voices_in,
  input  logic [NUM_VOICES-1:0]          voice_enable,
  input  logic [VOLBITS-1:0]             volume,
  output logic [BITDEPTH-1:0]            mix_out,
  output logic                           mix_valid,
  output logic                           overrun,
  output logic                           pdm_out
);

  localparam int IDXW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACCW = BITDEPTH + $clog2(NUM_VOICES) + 1;
  localparam int PW   = ACCW + VOLBITS + 1;

  localparam logic [BITDEPTH-1:0] MID = {1'b1, {(BITDEPTH-1){1'b0}}};
  localparam logic signed [PW-1:0] SMAX = {{(PW-BITDEPTH+1){1'b0}}, {(BITDEPTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = ~SMAX;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] SCALE = 2'd2;

  logic [1:0]                state;
  logic [IDXW-1:0]           idx;
  logic signed [ACCW-1:0]    acc;
  logic                      sc_q;
  logic                      armed;
  logic [BITDEPTH-1:0]       pdm_acc;
  logic                      sample_edge;
  logic [BITDEPTH-1:0]       voice_sel;
  logic signed [BITDEPTH:0]  term;
  logic signed [PW-1:0]      acc_w;
  logic signed [PW-1:0]      vol_w;
  logic signed [PW-1:0]      prod;
  logic signed [PW-1:0]      scaled;
  logic [BITDEPTH-1:0]       clamped;

  // armed masks the first cycle after reset so a level already high at release is not an edge
  assign sample_edge = sample_clock & ~sc_q & armed;

  always_comb begin
    voice_sel = voices_in[idx*BITDEPTH +: BITDEPTH];
    term      = '0;
    if (voice_enable[idx]) begin
      term = $signed({1'b0, voice_sel}) - $signed({1'b0, MID});
    end
  end

  always_comb begin
    acc_w  = PW'(acc);
    vol_w  = PW'($signed({1'b0, volume}));
    prod   = acc_w * vol_w;
    scaled = prod >>> VOLBITS;
    if (scaled > SMAX) begin
      clamped = SMAX[BITDEPTH-1:0];
    end else if (scaled < SMIN) begin
      clamped = SMIN[BITDEPTH-1:0];
    end else begin
      clamped = scaled[BITDEPTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      sc_q      <= 1'b0;
      armed     <= 1'b0;
      mix_out   <= MID;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sc_q      <= sample_clock;
      armed     <= 1'b1;
      mix_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_edge) begin
            state <= ACCUM;
            idx   <= '0;
            acc   <= '0;
          end
        end
        ACCUM: begin
          if (sample_edge) overrun <= 1'b1;
          acc <= acc + ACCW'(term);
          idx <= idx + 1'b1;
          if (idx == IDXW'(NUM_VOICES - 1)) state <= SCALE;
        end
        SCALE: begin
          if (sample_edge) overrun <= 1'b1;
          // two's complement to offset binary is a flip of the sign bit
          mix_out   <= {~clamped[BITDEPTH-1], clamped[BITDEPTH-2:0]};
          mix_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pdm_acc <= '0;
      pdm_out <= 1'b0;
    end else begin
      {pdm_out, pdm_acc} <= {1'b0, pdm_acc} + {1'b0, mix_out};
    end
  end

endmodule

// File: tb/tb_voice_mixer_pdm.sv
// tb/tb_voice_mixer_pdm.sv - directed self-checking bench for voice_mixer_pdm
module tb_voice_mixer_pdm;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_clock;
  logic [13:0] v [4];
  logic [55:0] voices_in;
  logic [3:0]  voice_enable;
  logic [7:0]  volume;
  logic [13:0] mix_out;
  logic        mix_valid;
  logic        overrun;
  logic        pdm_out;

  int checks = 0;
  int failures = 0;

  assign voices_in = {v[3], v[2], v[1], v[0]};

  always #5 clk = ~clk;

  voice_mixer_pdm dut (
    .clk          (clk),
    .rst          (rst),
    .sample_clock (sample_clock),
    .voices_in    (voices_in),
    .voice_enable (voice_enable),
    .volume       (volume),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .overrun      (overrun),
    .pdm_out      (pdm_out)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_voices(input int a, input int b, input int c, input int d);
    v[0] = 14'(a);
    v[1] = 14'(b);
    v[2] = 14'(c);
    v[3] = 14'(d);
  endtask

  // raise sample_clock, wait for the mix_valid pulse and check latency, value and pulse width
  task automatic sample(input string tag, input int exp_mix);
    int lat;
    lat = -1;
    @(negedge clk);
    sample_clock = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mix_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, 6);
    check({tag, "_mix"}, int'(mix_out), exp_mix);
    @(negedge clk);
    check({tag, "_pulse"}, int'(mix_valid), 0);
    sample_clock = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int ones;
    int same;
    int valids;
    logic prev;

    rst = 1'b0;
    sample_clock = 1'b0;
    set_voices(8192, 8192, 8192, 8192);
    voice_enable = 4'hF;
    volume = 8'd255;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample_clock = ~sample_clock;
    end
    check("rst_mix_out", int'(mix_out), 8192);
    check("rst_mix_valid", int'(mix_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_pdm_out", int'(pdm_out), 0);
    @(negedge clk);
    sample_clock = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    sample("silence", 8192);
    ones = 0;
    same = 0;
    prev = pdm_out;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ones += int'(pdm_out);
      if (pdm_out == prev) same++;
      prev = pdm_out;
    end
    check("pdm_half_ones", ones, 8);
    check("pdm_half_alternate", same, 0);

    set_voices(16383, 8192, 8192, 8192);
    sample("voice0_full", 16351);
    volume = 8'd0;
    sample("volume_zero", 8192);

    volume = 8'd255;
    set_voices(16383, 16383, 16383, 16383);
    sample("sat_high", 16383);
    set_voices(0, 0, 0, 0);
    sample("sat_low", 0);
    @(negedge clk);
    ones = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ones += int'(pdm_out);
    end
    check("pdm_zero_ones", ones, 0);

    set_voices(16383, 16383, 16383, 16383);
    voice_enable = 4'b0001;
    volume = 8'd128;
    sample("mask_vol128", 12287);

    voice_enable = 4'hF;
    volume = 8'd255;
    set_voices(16383, 8192, 8192, 8192);
    check("overrun_before", int'(overrun), 0);
    @(negedge clk);
    sample_clock = 1'b1;
    @(negedge clk);
    sample_clock = 1'b0;
    @(negedge clk);
    sample_clock = 1'b1;
    valids = -1;
    for (int k = 3; k <= 20; k++) begin
      @(negedge clk);
      if (mix_valid) begin
        valids = k;
        break;
      end
    end
    check("overrun_latency", valids, 6);
    check("overrun_mix", int'(mix_out), 16351);
    check("overrun_sticky", int'(overrun), 1);
    @(negedge clk);
    sample_clock = 1'b0;
    repeat (3) @(negedge clk);
    check("overrun_held", int'(overrun), 1);

    set_voices(16383, 16383, 16383, 16383);
    @(negedge clk);
    sample_clock = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_mix_out", int'(mix_out), 8192);
    check("abort_overrun", int'(overrun), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    valids = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      valids += int'(mix_valid);
    end
    check("abort_no_valid", valids, 0);
    check("abort_mix_kept", int'(mix_out), 8192);
    sample_clock = 1'b0;
    @(negedge clk);
    sample("after_abort", 16383);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
